// File: rtl/turn_signal_pkg.sv
// -----------------------------------------------------------------------------
// turn_signal_pkg
// Shared definitions for the turn-signal controller and the tail-light
// sequencer bench: the controller state encoding (also driven out on the
// 3-bit mode port), the request constants produced by switch decode, and the
// decode function itself.
// -----------------------------------------------------------------------------
package turn_signal_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LEFT  = 3'd2,
        RIGHT = 3'd3,
        HAZ   = 3'd4
    } state_t;

    // A request names the state the switches are asking for; CLEAR is never
    // requested, it is only the transit state between two active modes.
    localparam state_t REQ_NONE  = IDLE;
    localparam state_t REQ_LEFT  = LEFT;
    localparam state_t REQ_RIGHT = RIGHT;
    localparam state_t REQ_HAZ   = HAZ;

    // Both turn switches on at once is treated the same as the hazard switch.
    function automatic state_t decode_req(input logic hazard_in,
                                          input logic left_in,
                                          input logic right_in);
        if (hazard_in || (left_in && right_in)) return REQ_HAZ;
        if (left_in)                            return REQ_LEFT;
        if (right_in)                           return REQ_RIGHT;
        return REQ_NONE;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
// Single-input debounce filter for an already-synchronized switch. The
// filtered output only changes after DB_CYCLES consecutive samples that all
// differ from the current filtered value; any sample equal to the filtered
// value clears the run counter.
//
// Ports:
//   clk   - clock, all state on rising edge
//   reset - asynchronous active-high reset (filter and counter to 0)
//   din   - synchronized switch sample
//   dout  - filtered switch value
// -----------------------------------------------------------------------------
module switch_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    // Keep at least one counter bit so DB_CYCLES=1 still elaborates.
    localparam int            CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (din != filt_q) begin
            // The sample that completes the run flips the output and leaves
            // the counter at zero for the next change.
            if (cnt_q == CNT_MAX) begin
                filt_d = din;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/turn_signal_ctrl.sv
// -----------------------------------------------------------------------------
// turn_signal_ctrl
// Turns three raw switches (left, right, hazard) into registered left/right
// requests, a periodic step pulse and a mode code for the tail-light
// sequencer. Switches are 2-flop synchronized, optionally debounced, decoded
// into a request and fed to a five-state FSM. Moving between two active modes
// always passes through CLEAR (lights off) until the next step pulse.
//
// Build option:
//   DEBOUNCE_EN - when defined, each synchronized switch goes through a
//                 switch_debounce filter (DB_CYCLES samples). When undefined
//                 the synchronized value is used directly and DB_CYCLES has
//                 no effect.
//
// Ports:
//   clk       - clock, all state on rising edge
//   reset     - asynchronous active-high reset
//   left_sw   - raw left switch (asynchronous)
//   right_sw  - raw right switch (asynchronous)
//   hazard_sw - raw hazard switch (asynchronous)
//   left      - registered left request
//   right     - registered right request
//   step      - one-cycle pulse every TICK_DIV cycles
//   mode      - current state (turn_signal_pkg::state_t encoding)
// -----------------------------------------------------------------------------
module turn_signal_ctrl
    import turn_signal_pkg::*;
#(
    parameter int TICK_DIV  = 25000000,
    parameter int DB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_sw,
    input  logic       right_sw,
    input  logic       hazard_sw,
    output logic       left,
    output logic       right,
    output logic       step,
    output logic [2:0] mode
);

    localparam int            TW       = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    // Bit order for the switch vectors: 0 = left, 1 = right, 2 = hazard.
    logic [2:0] raw_sw;
    logic [2:0] sync1_q, sync2_q;
    logic [2:0] filt_sw;

    assign raw_sw = {hazard_sw, right_sw, left_sw};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_sw;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_filt
`ifdef DEBOUNCE_EN
            switch_debounce #(
                .DB_CYCLES(DB_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .reset(reset),
                .din  (sync2_q[gi]),
                .dout (filt_sw[gi])
            );
`else
            assign filt_sw[gi] = sync2_q[gi];
`endif
        end
    endgenerate

    state_t        state_q, state_d;
    state_t        pending_q, pending_d;
    state_t        req;
    logic          phase_q, phase_d;
    logic          left_q, left_d;
    logic          right_q, right_d;
    logic [TW-1:0] cnt_q, cnt_d;

    assign step = (cnt_q == TICK_MAX);

    always_comb begin
        req       = decode_req(filt_sw[2], filt_sw[0], filt_sw[1]);
        state_d   = state_q;
        pending_d = pending_q;
        phase_d   = phase_q;

        unique case (state_q)
            IDLE: begin
                if (req != IDLE) state_d = req;
            end
            CLEAR: begin
                // Keep following the switches; leave on the step edge into
                // whatever is requested at that moment.
                if (step) begin
                    state_d   = req;
                    pending_d = IDLE;
                end else begin
                    pending_d = req;
                end
            end
            LEFT, RIGHT, HAZ: begin
                if (req != state_q) begin
                    state_d   = CLEAR;
                    pending_d = req;
                end else if (state_q == HAZ && step) begin
                    phase_d = ~phase_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every state entry restarts the hazard phase and the step period, so
        // the first step lands TICK_DIV cycles after entry.
        if (state_d != state_q) phase_d = 1'b0;
        cnt_d = ((state_d != state_q) || step) ? '0 : cnt_q + TW'(1);

        // Lamp requests follow the next state directly: no extra pipeline.
        left_d  = (state_d == LEFT)  || ((state_d == HAZ) && !phase_d);
        right_d = (state_d == RIGHT) || ((state_d == HAZ) &&  phase_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= IDLE;
            phase_q   <= 1'b0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            phase_q   <= phase_d;
            left_q    <= left_d;
            right_q   <= right_d;
            cnt_q     <= cnt_d;
        end
    end

    assign left  = left_q;
    assign right = right_q;
    assign mode  = state_q;

endmodule

// File: doc/turn_signal_ctrl.md
TURN_SIGNAL_CTRL -- requirements
Module: turn_signal_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 25000000: clk cycles per step pulse (minimum 2).
REQ-002 The block SHALL have parameter DB_CYCLES, default 16: consecutive stable synced samples required to accept a switch change (minimum 1).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port left_sw, input, 1 bit: raw left-turn switch, asynchronous to clk.
REQ-006 The block SHALL have port right_sw, input, 1 bit: raw right-turn switch, asynchronous to clk.
REQ-007 The block SHALL have port hazard_sw, input, 1 bit: raw hazard switch, asynchronous to clk.
REQ-008 The block SHALL have port left, output, 1 bit: left request to the tail-light sequencer, registered.
REQ-009 The block SHALL have port right, output, 1 bit: right request to the tail-light sequencer, registered.
REQ-010 The block SHALL have port step, output, 1 bit: one-cycle pulse; the sequencer advances only on cycles with step=1.
REQ-011 The block SHALL have port mode, output, 3 bits: current state encoding, per the shared package.

Function
REQ-012 Each raw switch SHALL pass through a 2-flop synchronizer, giving 2 cycles of latency before filtering.
REQ-013 The tick counter SHALL count 0..TICK_DIV-1, wrap to 0, and assert step in the cycle it equals TICK_DIV-1.
REQ-014 The tick counter SHALL be cleared to 0 in the cycle after any state change, so the first step comes TICK_DIV cycles after entry.
REQ-015 Request decode from filtered switches SHALL be: hazard_sw or (left_sw and right_sw) -> HAZ; left_sw only -> LEFT; right_sw only -> RIGHT; none -> IDLE.
REQ-016 The FSM SHALL have the states IDLE, CLEAR, LEFT, RIGHT and HAZ.
REQ-017 From IDLE, a non-idle request SHALL enter the requested state on the next clk.
REQ-018 From LEFT, RIGHT or HAZ, a request that differs from the current state SHALL go to CLEAR and latch the pending request.
REQ-019 CLEAR SHALL hold left=right=0 until the first step pulse, then enter the pending state, re-evaluated at that edge (IDLE if none).
REQ-020 A request change while in CLEAR SHALL update the pending request without restarting the counter.
REQ-021 Outputs SHALL be: IDLE/CLEAR give left=0, right=0; LEFT gives left=1, right=0; RIGHT gives left=0, right=1.
REQ-022 HAZ SHALL keep a phase bit, cleared on entry and toggled on each step, giving left=~phase and right=phase, so left and right never assert together.
REQ-023 left and right SHALL be updated in the same cycle as state and phase, with no extra pipeline stage.
REQ-024 step SHALL pulse in every state, including IDLE.

Reset
REQ-025 While reset=1, the block SHALL hold state=IDLE, pending=IDLE, counter=0, phase=0, synchronizer and filter flops=0, left=0, right=0, step=0 and mode=IDLE.
REQ-026 A reset asserted mid-sequence SHALL take effect immediately and asynchronously; after release, an active switch is treated as a new request from IDLE.

Configuration
REQ-027 When DEBOUNCE_EN is defined, each synced switch SHALL change its filtered value only after DB_CYCLES consecutive equal samples that differ from the current filtered value (per-input counter, cleared on any mismatch).
REQ-028 When DEBOUNCE_EN is undefined, the filtered value SHALL equal the synced value, DB_CYCLES SHALL be ignored, and no filter counters SHALL be built.

Structure
REQ-029 The state typedef (IDLE=0, CLEAR=1, LEFT=2, RIGHT=3, HAZ=4) and request decode constants SHALL live in package turn_signal_pkg, shared with the tail-light bench.
REQ-030 The debounce filter SHALL be a single-input sub-module, switch_debounce, instantiated three times.
REQ-031 The counter width SHALL be $clog2(TICK_DIV).

Verification (TICK_DIV=4, DB_CYCLES=3, DEBOUNCE_EN defined)
REQ-032 The bench SHALL check: reset released, all switches 0 for 20 cycles -> left=right=0, step every 4th cycle, mode=IDLE.
REQ-033 The bench SHALL check: left_sw=1 held -> mode=LEFT 2+3+1 cycles later, left=1, right=0, first step 4 cycles after entry.
REQ-034 The bench SHALL check: in LEFT, right_sw=1 and left_sw=0 -> mode=CLEAR with left=right=0 until the next step, then mode=RIGHT with right=1.
REQ-035 The bench SHALL check: hazard_sw=1 -> after CLEAR, mode=HAZ with left=1, right=0, then swapping on each step; never both high.
REQ-036 The bench SHALL check: left_sw 1-cycle glitches at 2-cycle spacing -> no mode change; without DEBOUNCE_EN, the same stimulus changes mode.
REQ-037 The bench SHALL check: reset pulsed mid-HAZ asynchronously (between edges) -> left=right=0 and mode=IDLE before the next clk edge.
